led_shift_sequencer: RTL
========================

LED_SHIFT_SEQUENCER -- requirements
Module: led_shift_sequencer

Interface
REQ-001 Parameter N_LEDS, default 8: LED array width; legal range 2..32.
REQ-002 Parameter TICKS_PER_STEP, default 4: number of tiks edges per pattern step; legal range 1..255.
REQ-003 clock  input  1  system clock; all logic is on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 tiks  input  1  square wave from the tick generator; both edges count as step events.
REQ-006 start  input  1  single-cycle request to begin a sequence.
REQ-007 stop  input  1  single-cycle request to abort the sequence.
REQ-008 mode  input  2  pattern select: 0 = rotate-left, 1 = rotate-right, 2 = bounce, 3 = hold.
REQ-009 run_count  input  8  number of passes before completion; 0 means run forever.
REQ-010 leds  output  N_LEDS  one-hot LED pattern; all zero when not running.
REQ-011 busy  output  1  high while in state RUN.
REQ-012 wrap  output  1  single-cycle pulse on each completed pass.
REQ-013 done  output  1  single-cycle pulse when run_count passes have completed.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 Step event: tiks XOR tiks_q, where tiks_q is tiks registered each cycle.
REQ-016 IDLE to RUN: on start=1 with stop=0; the same edge latches mode and run_count, sets leds to bit0, zeroes the prescaler and pass counter, and sets the bounce direction to up.
REQ-017 start SHALL be ignored in RUN and DONE; mode and run_count changes during RUN SHALL be ignored.
REQ-018 Prescaler: in RUN, each step event increments the prescaler; the step that reaches TICKS_PER_STEP-1 advances the pattern and clears the prescaler to 0.
REQ-019 The pattern SHALL advance on the clock edge immediately following the qualifying step event (latency 1 cycle).
REQ-020 Rotate-left SHALL move bit i to i+1, with bit N_LEDS-1 wrapping to bit0.
REQ-021 Rotate-right SHALL move bit i to i-1, with bit0 wrapping to bit N_LEDS-1.
REQ-022 Bounce: the hot bit moves up to N_LEDS-1, reverses without dwelling, moves down to bit0, then reverses again.
REQ-023 Hold: leds SHALL stay at bit0; no passes occur.
REQ-024 Pass: any advance whose result is leds == bit0; wrap pulses in the same cycle as that leds update.
REQ-025 Pass counter: 8-bit; if run_count != 0 and the pass just completed is the run_count-th, the FSM goes to DONE on the same edge as the wrap pulse.
REQ-026 If run_count == 0, the pass counter SHALL saturate at 255 and never trigger DONE.
REQ-027 DONE: lasts exactly one cycle with done=1 and leds=0, then returns to IDLE.
REQ-028 stop in RUN: next state is IDLE with leds=0; no done pulse; any pending step or wrap is discarded.
REQ-029 start and stop in the same cycle: stop wins.
REQ-030 stop in IDLE or DONE SHALL have no effect.
REQ-031 busy SHALL be 1 exactly in RUN; done and busy are never high together.

Reset
REQ-032 While rst=0: state=IDLE; leds=0; busy=0; wrap=0; done=0; prescaler=0; pass counter=0; tiks_q=0; direction=up.
REQ-033 Reset asserted mid-RUN SHALL abort the sequence on the next edge without a done pulse.
REQ-034 The first cycle after reset release may register a step event if tiks=1; this event SHALL be ignored because the FSM is in IDLE.

Structure
REQ-035 A shared package SHALL hold the mode encodings (MODE_LEFT/RIGHT/BOUNCE/HOLD) and the state encodings.
REQ-036 Edge detection and the prescaler SHALL live in one sub-module, step_prescaler, whose output is a single-cycle step pulse and which has a clear input driven by the FSM.
REQ-037 The pattern and FSM logic SHALL be in the top module; no other sub-modules.

Verification (N_LEDS=8, TICKS_PER_STEP=2)
REQ-038 Left run: mode=0, run_count=1, start -> leds 0x01,0x02,...,0x80,0x01 every 2 tiks edges; wrap and DONE fire on the return to 0x01; done=1 for 1 cycle; leds=0; busy=0.
REQ-039 Right run: mode=1, run_count=2 -> first step 0x80; two wrap pulses; done after 16 steps.
REQ-040 Bounce: mode=2, run_count=1 -> 0x01,...,0x80,0x40,...,0x01 (14 steps); a single wrap then done.
REQ-041 Abort: stop at step 3 of an infinite left run -> next cycle leds=0, busy=0, done never asserted; a simultaneous start+stop in IDLE leaves busy=0.
REQ-042 Reset mid-RUN: rst=0 for 1 cycle -> all outputs 0; a later start restarts at 0x01 with the prescaler at 0.
REQ-043 Hold: mode=3 run with 100 tiks edges -> leds stays 0x01, no wrap, busy stays 1 until stop.

Source files
------------

// File: rtl/led_shift_sequencer_pkg.sv
// Shared encodings for the LED shift sequencer: pattern modes, FSM states
// and the width of the pass/run counters.
package led_shift_sequencer_pkg;

  localparam int unsigned COUNT_W = 8;

  typedef enum logic [1:0] {
    MODE_LEFT   = 2'd0,
    MODE_RIGHT  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/led_shift_sequencer_step_prescaler.sv
// step_prescaler: detects both edges of the tick square wave and divides them
// down to one step pulse every TICKS_PER_STEP edges.
//   clock  : system clock, rising edge
//   rst    : synchronous active-low reset
//   tiks   : tick square wave, both edges count
//   clear  : holds the prescaler at 0 and suppresses step_c
//   step_c : combinational single-cycle step pulse (acted on at the next edge)
module step_prescaler #(
  parameter int unsigned TICKS_PER_STEP = 4
) (
  input  logic clock,
  input  logic rst,
  input  logic tiks,
  input  logic clear,
  output logic step_c
);

  localparam int unsigned PW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICKS_PER_STEP - 1);

  logic          tiks_q;
  logic [PW-1:0] presc_q;
  logic          edge_c;

  assign edge_c = tiks ^ tiks_q;
  assign step_c = !clear && edge_c && (presc_q == LAST);

  // Edge history register and edge counter that wraps on the qualifying edge.
  always_ff @(posedge clock) begin
    if (!rst) begin
      tiks_q  <= 1'b0;
      presc_q <= '0;
    end else begin
      tiks_q <= tiks;
      if (clear) begin
        presc_q <= '0;
      end else if (edge_c) begin
        presc_q <= (presc_q == LAST) ? '0 : presc_q + PW'(1);
      end
    end
  end

endmodule

// File: rtl/led_shift_sequencer.sv
// led_shift_sequencer: walks a one-hot bit across an LED array in rotate-left,
// rotate-right, bounce or hold mode, advancing once per TICKS_PER_STEP tick
// edges, and stops after run_count passes (0 = run forever).
//   clock, rst     : system clock, synchronous active-low reset
//   tiks           : tick square wave (both edges are step events)
//   start, stop    : single-cycle run/abort requests (stop wins)
//   mode           : pattern select, latched at start
//   run_count      : passes before completion, latched at start
//   leds           : one-hot pattern, zero outside RUN
//   busy           : high while running
//   wrap, done     : single-cycle pass-complete / sequence-complete pulses
module led_shift_sequencer
  import led_shift_sequencer_pkg::*;
#(
  parameter int unsigned N_LEDS         = 8,
  parameter int unsigned TICKS_PER_STEP = 4
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               tiks,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [COUNT_W-1:0] run_count,
  output logic [N_LEDS-1:0]  leds,
  output logic               busy,
  output logic               wrap,
  output logic               done
);

  localparam logic [N_LEDS-1:0]  BIT0    = N_LEDS'(1);
  localparam logic [N_LEDS-1:0]  TOP     = {1'b1, {(N_LEDS-1){1'b0}}};
  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [COUNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [COUNT_W-1:0] pass_q, pass_d;
  logic               dir_up_q, dir_up_d;
  logic [N_LEDS-1:0]  leds_q, leds_d;
  logic               wrap_q, wrap_d;
  logic               done_q, busy_q;

  logic               step_c;
  logic               presc_clear_c;
  logic [N_LEDS-1:0]  adv_c;
  logic               adv_dir_up_c;

  // Prescaler only runs in RUN; a stop in the same cycle discards a pending step.
  assign presc_clear_c = (state_q != ST_RUN) || stop;

  step_prescaler #(
    .TICKS_PER_STEP(TICKS_PER_STEP)
  ) u_step_prescaler (
    .clock  (clock),
    .rst    (rst),
    .tiks   (tiks),
    .clear  (presc_clear_c),
    .step_c (step_c)
  );

  // Next pattern for one advance; bounce flips direction on reaching either end.
  always_comb begin
    adv_c        = leds_q;
    adv_dir_up_c = dir_up_q;
    case (mode_q)
      MODE_LEFT:  adv_c = {leds_q[N_LEDS-2:0], leds_q[N_LEDS-1]};
      MODE_RIGHT: adv_c = {leds_q[0], leds_q[N_LEDS-1:1]};
      MODE_BOUNCE: begin
        if (dir_up_q) begin
          adv_c = leds_q << 1;
          if (adv_c == TOP) adv_dir_up_c = 1'b0;
        end else begin
          adv_c = leds_q >> 1;
          if (adv_c == BIT0) adv_dir_up_c = 1'b1;
        end
      end
      default:    adv_c = leds_q;
    endcase
  end

  // FSM next state and datapath updates.
  // The final pass goes straight to DONE, so that wrap cycle shows leds=0.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    run_cnt_d = run_cnt_q;
    pass_d    = pass_q;
    dir_up_d  = dir_up_q;
    leds_d    = leds_q;
    wrap_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        leds_d = '0;
        if (start && !stop) begin
          state_d   = ST_RUN;
          mode_d    = mode_e'(mode);
          run_cnt_d = run_count;
          pass_d    = '0;
          dir_up_d  = 1'b1;
          leds_d    = BIT0;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
          leds_d  = '0;
        end else if (step_c && (mode_q != MODE_HOLD)) begin
          leds_d   = adv_c;
          dir_up_d = adv_dir_up_c;
          if (adv_c == BIT0) begin
            wrap_d = 1'b1;
            if (pass_q != CNT_MAX) pass_d = pass_q + COUNT_W'(1);
            if ((run_cnt_q != '0) && ((pass_q + COUNT_W'(1)) == run_cnt_q)) begin
              state_d = ST_DONE;
              leds_d  = '0;
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        leds_d  = '0;
      end
      default: begin
        state_d = ST_IDLE;
        leds_d  = '0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clock) begin
    if (!rst) begin
      mode_q    <= MODE_LEFT;
      run_cnt_q <= '0;
      pass_q    <= '0;
      dir_up_q  <= 1'b1;
      leds_q    <= '0;
      wrap_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      run_cnt_q <= run_cnt_d;
      pass_q    <= pass_d;
      dir_up_q  <= dir_up_d;
      leds_q    <= leds_d;
      wrap_q    <= wrap_d;
      done_q    <= (state_d == ST_DONE);
      busy_q    <= (state_d == ST_RUN);
    end
  end

  assign leds = leds_q;
  assign wrap = wrap_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule
